// File: rtl/reward_pkg.sv
// reward_pkg: shared state/type encodings, default grid size and LFSR step for the reward spawner.
package reward_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, COOLDOWN = 2'd1, DRAW = 2'd2, PRESENT = 2'd3} state_t;
  typedef enum logic [1:0] {NONE = 2'd0, PROTECT = 2'd1, SLOW = 2'd2, GRADE = 2'd3} reward_t;
  localparam int DEF_GRID_W = 40;
  localparam int DEF_GRID_H = 30;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  // A zero state would lock the Galois register, so it reloads the seed instead.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s, input logic [15:0] seed);
    return s == 16'h0 ? seed : (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0);
  endfunction
endpackage

// File: rtl/reward_lfsr16.sv
// reward_lfsr16: free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) with seed reload on zero.
module reward_lfsr16 import reward_pkg::*; #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);
  logic [15:0] r_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_q <= SEED;
    else     r_q <= lfsr_next(r_q, SEED);
  assign q = r_q;
endmodule

// File: rtl/reward_spawner.sv
// reward_spawner: draws a random reward cell/type and holds it on the set_require/set_finish handshake.
// Optional display flashing near expiry is built when REWARD_BLINK_EN is defined.
module reward_spawner import reward_pkg::*; #(
  parameter int          GRID_W         = DEF_GRID_W,
  parameter int          GRID_H         = DEF_GRID_H,
  parameter int          COOLDOWN_TICKS = 8,
  parameter int          LIFETIME_TICKS = 40,
  parameter int          MAX_RETRY      = 64,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_4Hz,
  input  logic        enable,
  input  logic [5:0]  head_x,
  input  logic [5:0]  head_y,
  input  logic        set_finish,
  output logic        set_require,
  output logic [1:0]  reward_type,
  output logic [5:0]  random_xpos,
  output logic [5:0]  random_ypos,
  output logic [15:0] dout,
  output logic        reward_blink
);
  localparam int TMAX = COOLDOWN_TICKS > LIFETIME_TICKS ? COOLDOWN_TICKS : LIFETIME_TICKS;
  localparam int CW   = $clog2(TMAX + 1);
  logic [15:0]   w_lfsr;
  logic [1:0]    r_sync;
  logic          r_prev, r_tick;
  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt, w_cnt_inc;
  logic [6:0]    r_retry, w_retry, w_fx_sum;
  logic          r_req, w_req, w_ok, w_fb, w_life_done;
  logic [1:0]    r_type, w_type;
  logic [5:0]    r_x, w_x, r_y, w_y, w_fx;
  reward_lfsr16 #(.SEED(SEED)) u_lfsr (.clk(clk), .rst(rst), .q(w_lfsr));
  // clk_4Hz is asynchronous to clk; the registered edge lands 3 clk after its rise.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], clk_4Hz};
      r_prev <= r_sync[1];
      r_tick <= r_sync[1] & ~r_prev;
    end
  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_life_done = r_tick && w_cnt_inc == CW'(LIFETIME_TICKS);
  assign w_ok        = int'(w_lfsr[5:0]) < GRID_W && int'(w_lfsr[11:6]) < GRID_H &&
                       w_lfsr[13:12] != NONE && {w_lfsr[5:0], w_lfsr[11:6]} != {head_x, head_y};
  assign w_fb        = r_retry == 7'(MAX_RETRY);
  assign w_fx_sum    = 7'(head_x) + 7'(GRID_W / 2);
  assign w_fx        = 6'(w_fx_sum % 7'(GRID_W));
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_retry = r_retry;
    w_req   = r_req;
    w_type  = r_type;
    w_x     = r_x;
    w_y     = r_y;
    case (r_state)
      IDLE: begin
        w_cnt = '0;
        if (enable) w_state = COOLDOWN;
      end
      COOLDOWN: if (r_tick) begin
        w_cnt = w_cnt_inc;
        if (w_cnt_inc == CW'(COOLDOWN_TICKS)) begin
          w_state = DRAW;
          w_retry = '0;
        end
      end
      DRAW: if (w_fb || w_ok) begin
        w_state = PRESENT;
        w_cnt   = '0;
        w_req   = 1'b1;
        w_type  = w_fb ? PROTECT : w_lfsr[13:12];
        w_x     = w_fb ? w_fx : w_lfsr[5:0];
        w_y     = w_fb ? head_y : w_lfsr[11:6];
      end else w_retry = r_retry + 1'b1;
      PRESENT: if (set_finish || w_life_done) begin
        w_state = COOLDOWN;
        w_cnt   = '0;
        w_req   = 1'b0;
        w_type  = NONE;
      end else if (r_tick) w_cnt = w_cnt_inc;
      default: w_state = IDLE;
    endcase
    if (!enable) begin
      w_state = IDLE;
      w_cnt   = '0;
      w_retry = '0;
      w_req   = 1'b0;
      w_type  = NONE;
      w_x     = '0;
      w_y     = '0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_retry <= '0;
      r_req   <= 1'b0;
      r_type  <= NONE;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_retry <= w_retry;
      r_req   <= w_req;
      r_type  <= w_type;
      r_x     <= w_x;
      r_y     <= w_y;
    end
`ifdef REWARD_BLINK_EN
  logic r_blink, w_near;
  assign w_near = int'(w_cnt_inc) + 8 >= LIFETIME_TICKS;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_blink <= 1'b0;
    else     r_blink <= (r_state == PRESENT && w_state == PRESENT) ? r_blink ^ (r_tick & w_near) : 1'b0;
  assign reward_blink = r_blink;
`else
  assign reward_blink = 1'b0;
`endif
  assign set_require = r_req;
  assign reward_type = r_type;
  assign random_xpos = r_x;
  assign random_ypos = r_y;
  assign dout        = w_lfsr;
endmodule

// File: tb/tb_reward_spawner.sv
// tb_reward_spawner: directed checks of draw, collect, expiry, fallback, enable drop and async reset.
module tb_reward_spawner;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef REWARD_BLINK_EN
  localparam logic BLINK = 1'b1;
`else
  localparam logic BLINK = 1'b0;
`endif
  logic clk = 0, rst = 1, clk_4Hz = 0, enable = 0, set_finish = 0, en2 = 0;
  logic [5:0] head_x = 6'd5, head_y = 6'd5;
  logic req, blink, req2, blink2;
  logic [1:0] rtype, rtype2;
  logic [5:0] rx, ry, rx2, ry2, sx, sy;
  logic [15:0] dout, dout2, m, mb;
  int checks = 0, errors = 0;
  bit chase = 0;

  always #5 clk = ~clk;

  // Reference LFSR; mb holds the state the DUT used at the most recent edge.
  always @(posedge clk or posedge rst)
    if (rst) begin
      m  <= SEED;
      mb <= SEED;
    end else begin
      m  <= (m == 16'h0) ? SEED : ((m >> 1) ^ (m[0] ? 16'hB400 : 16'h0));
      mb <= m;
    end

  reward_spawner #(.GRID_W(40), .GRID_H(30), .COOLDOWN_TICKS(2), .LIFETIME_TICKS(3),
                   .MAX_RETRY(64), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .clk_4Hz(clk_4Hz), .enable(enable), .head_x(head_x), .head_y(head_y),
    .set_finish(set_finish), .set_require(req), .reward_type(rtype), .random_xpos(rx),
    .random_ypos(ry), .dout(dout), .reward_blink(blink));

  reward_spawner #(.GRID_W(1), .GRID_H(1), .COOLDOWN_TICKS(2), .LIFETIME_TICKS(40),
                   .MAX_RETRY(1), .SEED(SEED)) dut2 (
    .clk(clk), .rst(rst), .clk_4Hz(clk_4Hz), .enable(en2), .head_x(6'd0), .head_y(6'd0),
    .set_finish(1'b0), .set_require(req2), .reward_type(rtype2), .random_xpos(rx2),
    .random_ypos(ry2), .dout(dout2), .reward_blink(blink2));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // When chasing, the head sits on the very cell the LFSR offers at the next edge.
  task automatic step();
    @(negedge clk);
    if (chase) begin
      head_x = m[5:0];
      head_y = m[11:6];
    end
  endtask

  // Returns on the negedge right after the FSM has consumed the tick.
  task automatic tick();
    clk_4Hz = 0;
    repeat (3) step();
    clk_4Hz = 1;
    repeat (4) step();
  endtask

  task automatic wait_req(input logic lvl, input int budget, input string tag);
    int n;
    n = 0;
    while (req !== lvl && n < budget) begin
      step();
      n++;
    end
    chk(tag, 16'(req), 16'(lvl));
  endtask

  task automatic chk_cand(input string t);
    chk({t, "_x"}, 16'(rx), 16'(mb[5:0]));
    chk({t, "_y"}, 16'(ry), 16'(mb[11:6]));
    chk({t, "_type"}, 16'(rtype), 16'(mb[13:12]));
    chk({t, "_range"}, 16'(rx < 6'd40 && ry < 6'd30 && rtype != 2'd0), 16'd1);
    chk({t, "_nothead"}, 16'({rx, ry} != {head_x, head_y}), 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    chk("rst_req", 16'(req), 16'd0);
    chk("rst_type", 16'(rtype), 16'd0);
    chk("rst_x", 16'(rx), 16'd0);
    chk("rst_y", 16'(ry), 16'd0);
    chk("rst_blink", 16'(blink), 16'd0);
    chk("rst_dout", dout, 16'hACE1);
    rst = 0;
    step();
    chk("lfsr_first_step", dout, 16'hE270);
    enable = 1;
    en2 = 1;
    tick();
    chk("cooldown_1tick", 16'(req), 16'd0);
    tick();
    wait_req(1'b1, 68, "draw1_rise");
    chk_cand("draw1");
    chk("blink_entry", 16'(blink), 16'd0);
    repeat (4) step();
    chk("fb1_req", 16'(req2), 16'd1);
    chk("fb1_x", 16'(rx2), 16'd0);
    chk("fb1_y", 16'(ry2), 16'd0);
    chk("fb1_type", 16'(rtype2), 16'd1);
    sx = rx;
    sy = ry;
    set_finish = 1;
    step();
    set_finish = 0;
    chk("collect_req", 16'(req), 16'd0);
    chk("collect_type", 16'(rtype), 16'd0);
    chk("collect_xhold", 16'(rx), 16'(sx));
    chk("collect_yhold", 16'(ry), 16'(sy));
    tick();
    chk("collect_cd1", 16'(req), 16'd0);
    tick();
    wait_req(1'b1, 68, "draw2_rise");
    chk_cand("draw2");
    tick();
    chk("life_t1_req", 16'(req), 16'd1);
    chk("blink_t1", 16'(blink), 16'(BLINK));
    tick();
    chk("life_t2_req", 16'(req), 16'd1);
    chk("blink_t2", 16'(blink), 16'd0);
    tick();
    chk("expire_req", 16'(req), 16'd0);
    chk("expire_type", 16'(rtype), 16'd0);
    tick();
    chk("expire_cd1", 16'(req), 16'd0);
    tick();
    wait_req(1'b1, 68, "draw3_rise");
    chk_cand("draw3");
    tick();
    tick();
    clk_4Hz = 0;
    repeat (3) step();
    clk_4Hz = 1;
    repeat (3) step();
    set_finish = 1;
    step();
    set_finish = 0;
    chk("coincide_req", 16'(req), 16'd0);
    chk("coincide_type", 16'(rtype), 16'd0);
    step();
    chk("coincide_hold", 16'(req), 16'd0);
    tick();
    chk("coincide_cd1", 16'(req), 16'd0);
    tick();
    wait_req(1'b1, 68, "draw4_rise");
    chk_cand("draw4");
    set_finish = 1;
    step();
    set_finish = 0;
    chase = 1;
    tick();
    tick();
    wait_req(1'b1, 68, "fallback_rise");
    chk("fallback_x", 16'(rx), 16'((int'(mb[5:0]) + 20) % 40));
    chk("fallback_y", 16'(ry), 16'(mb[11:6]));
    chk("fallback_type", 16'(rtype), 16'd1);
    chase = 0;
    step();
    enable = 0;
    step();
    chk("disable_req", 16'(req), 16'd0);
    chk("disable_type", 16'(rtype), 16'd0);
    chk("disable_x", 16'(rx), 16'd0);
    chk("disable_y", 16'(ry), 16'd0);
    chk("disable_blink", 16'(blink), 16'd0);
    chk("disable_lfsr_kept", dout, m);
    tick();
    tick();
    chk("idle_hold", 16'(req), 16'd0);
    chk("inst2_still_presented", 16'(req2), 16'd1);
    #2 rst = 1;
    #1;
    chk("async_rst_req", 16'(req2), 16'd0);
    chk("async_rst_type", 16'(rtype2), 16'd0);
    chk("async_rst_x", 16'(rx2), 16'd0);
    chk("async_rst_dout", dout2, 16'hACE1);
    step();
    rst = 0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reward_spawner.md
Name: reward_spawner

Overview:
Producer end of the reward set_require/set_finish handshake. Picks a pseudo-random grid cell and reward type, then presents the reward with set_require high until the consumer pulses set_finish or the lifetime expires. After a cooldown it spawns the next reward. It sits beside the snake game logic and drives the reward position/type seen by the consumer and the reward display.

Parameters:
GRID_W, 40, playfield width in cells; legal x is 0..GRID_W-1 (max 63)
GRID_H, 30, playfield height in cells; legal y is 0..GRID_H-1 (max 63)
COOLDOWN_TICKS, 8, 4 Hz ticks between reward removal and the next draw (2 s)
LIFETIME_TICKS, 40, 4 Hz ticks a reward stays presented before it expires (10 s)
MAX_RETRY, 64, rejected draws allowed before the fallback cell is used
SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
clk_4Hz  in  1  slow game clock, treated as asynchronous data and edge-detected
enable  in  1  high while the game is running
head_x  in  6  snake head x cell
head_y  in  6  snake head y cell
set_finish  in  1  consumer pulse: reward collected
set_require  out  1  high while a valid reward is presented
reward_type  out  2  1=protect, 2=slow, 3=grade; 0 only when nothing is presented
random_xpos  out  6  reward x cell
random_ypos  out  6  reward y cell
dout  out  16  raw LFSR state, for debug
reward_blink  out  1  display flash hint (see Optional Feature)

Behaviour:
- Reset: all outputs 0, state IDLE, LFSR=SEED, counters 0.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400). Steps every clk cycle while not in reset, in every state. If the state ever reads 0, reload SEED.
- Tick generation: 2-flop synchronizer on clk_4Hz, then rising-edge detect. Produces a one-clk tick pulse 3 clk after the clk_4Hz edge.
- States: IDLE, COOLDOWN, DRAW, PRESENT.
- IDLE: outputs 0. enable=1 -> COOLDOWN with tick counter cleared.
- COOLDOWN: count ticks. When count reaches COOLDOWN_TICKS -> DRAW with retry counter cleared.
- DRAW, one candidate per clk:
  - Candidate: x=lfsr[5:0], y=lfsr[11:6], type=lfsr[13:12].
  - Accept when x<GRID_W, y<GRID_H, type!=0, and (x,y)!=(head_x,head_y).
  - On accept: latch x, y, type into the outputs; set_require=1 on the next clk; -> PRESENT with tick counter cleared.
  - On reject: retry+1.
  - When retry reaches MAX_RETRY: fallback x=(head_x+GRID_W/2) mod GRID_W, y=head_y, type=1; then the same accept path.
- PRESENT: outputs stable.
  - set_finish=1: set_require and reward_type go to 0 the next clk; x/y hold; -> COOLDOWN.
  - Tick count reaches LIFETIME_TICKS: same clearing; -> COOLDOWN (expired).
  - set_finish and the expiry tick in the same clk: treated as collected; single transition.
- set_finish outside PRESENT is ignored.
- enable=0 in any state: synchronous return to IDLE next clk, set_require=0, type/x/y=0, counters cleared. The LFSR is not reset.
- Reset asserted mid-PRESENT: immediate clear of all outputs (asynchronous).
- Counter widths: ceil(log2(max(COOLDOWN_TICKS, LIFETIME_TICKS)+1)) bits for the tick counter; 7 bits for retry.

Optional Feature:
REWARD_BLINK_EN.
- Defined: in PRESENT, reward_blink toggles on every tick once remaining ticks <=8. It is 0 in all other states and on entry to PRESENT.
- Undefined: reward_blink is tied to 0 and there is no blink logic.

Decomposition:
- Package reward_pkg holds:
  - state encoding (IDLE=0, COOLDOWN=1, DRAW=2, PRESENT=3)
  - reward type codes (NONE=0, PROTECT=1, SLOW=2, GRADE=3)
  - default GRID_W/GRID_H
  - LFSR mask 16'hB400
- Sub-module reward_lfsr16 (clk, rst, seed reload, 16-bit state out); the FSM, tick detect and counters stay in reward_spawner.

Test Plan:
- Reset, then enable=1 with COOLDOWN_TICKS=2 and 4 Hz edges -> set_require rises within 2 ticks + MAX_RETRY+4 clk; x<40, y<30, type in 1..3.
- Present reward, pulse set_finish for 1 clk -> set_require=0 and reward_type=0 next clk; a new reward appears after 2 more ticks.
- No set_finish, LIFETIME_TICKS=3 -> set_require drops exactly on the 3rd tick after presentation, then cooldown restarts.
- Force head_x/head_y to the LFSR's first candidate cell -> that candidate is rejected; the accepted cell differs from the head.
- MAX_RETRY=1 with GRID_W=1, GRID_H=1, head=(0,0) -> fallback x=0, y=0, type=1 presented.
- enable dropped mid-PRESENT, and set_finish coincident with the expiry tick -> IDLE with all outputs 0; collision case counts as collected (one transition, no glitch on set_require).
